data_mem_ctrl: RTL and testbench

Multi-cycle data memory responder for the processor's memory stage. It accepts the load/store requests that the pipeline encodes through its mem_read / mem_write / mem_byte controls, performs word or byte accesses on an internal word-organised array after a fixed latency, and returns load data with a one-cycle response pulse. While an access is outstanding it drives a stall to the pipeline.

---
 rtl/data_mem_ctrl.sv | 140 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory responder for the memory stage.
// Word/byte loads and stores on a word array after a fixed latency.
module data_mem_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic        req_byte,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        stall
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESPOND
   } state_t;

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t                  state_q;
   logic [3:0]              cnt_q;
   logic                    wr_q;
   logic                    byte_q;
   logic [ADDR_WIDTH-1:0]   idx_q;
   logic [1:0]              lane_q;
   logic [31:0]             wdata_q;
   logic                    ready_q;
   logic                    valid_q;
   logic [31:0]             rdata_q;
   logic [31:0]             mem_q [DEPTH];

   logic                    idle;
   logic                    commit;
   logic                    acc_wr;
   logic                    acc_byte;
   logic [ADDR_WIDTH-1:0]   acc_idx;
   logic [1:0]              acc_lane;
   logic [31:0]             acc_wdata;
   logic [31:0]             rd_word;
   logic [31:0]             wr_word;
   logic [31:0]             ld_data;
   logic                    unused_addr;

   assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

   assign idle = (state_q == IDLE);

   // With LATENCY=1 the commit edge is the acceptance edge itself,
   // so the live request fields feed the array instead of the latches.
   assign commit = (idle && req_valid && (LATENCY == 1))
                || (state_q == ACCESS && cnt_q == 4'd1);

   assign acc_wr    = idle ? req_write : wr_q;
   assign acc_byte  = idle ? req_byte  : byte_q;
   assign acc_idx   = idle ? req_addr[ADDR_WIDTH+1:2] : idx_q;
   assign acc_lane  = idle ? req_addr[1:0] : lane_q;
   assign acc_wdata = idle ? req_wdata : wdata_q;

   assign rd_word = mem_q[acc_idx];

   always_comb begin
      wr_word = acc_wdata;
      ld_data = rd_word;
      if (acc_byte) begin
         wr_word = rd_word;
         wr_word[{acc_lane, 3'b000} +: 8] = acc_wdata[7:0];
         ld_data = {24'd0, rd_word[{acc_lane, 3'b000} +: 8]};
      end
   end

   assign stall      = (idle && req_valid) || (state_q == ACCESS);
   assign req_ready  = ready_q;
   assign resp_valid = valid_q;
   assign resp_rdata = rdata_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         byte_q  <= 1'b0;
         idx_q   <= '0;
         lane_q  <= '0;
         wdata_q <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         rdata_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         valid_q <= commit;
         if (commit) begin
            if (acc_wr) begin
               mem_q[acc_idx] <= wr_word;
            end else begin
               rdata_q <= ld_data;
            end
         end
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  wr_q    <= req_write;
                  byte_q  <= req_byte;
                  idx_q   <= req_addr[ADDR_WIDTH+1:2];
                  lane_q  <= req_addr[1:0];
                  wdata_q <= req_wdata;
                  cnt_q   <= CNT_INIT;
                  ready_q <= 1'b0;
                  state_q <= (LATENCY == 1) ? RESPOND : ACCESS;
               end
            end
            ACCESS: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= RESPOND;
               end
            end
            RESPOND: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: LATENCY=3 and LATENCY=1 instances
// checked each cycle against a timing/array reference model.
module tb_data_mem_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        rv [2];
   logic        rw [2];
   logic        rb [2];
   logic [31:0] ra [2];
   logic [31:0] wd [2];
   logic        rdy [2];
   logic        vld [2];
   logic        stl [2];
   logic [31:0] rd [2];

   data_mem_ctrl #(.ADDR_WIDTH(8), .LATENCY(3)) dut0 (
      .clock(clk), .reset(rst),
      .req_valid(rv[0]), .req_write(rw[0]), .req_byte(rb[0]),
      .req_addr(ra[0]), .req_wdata(wd[0]),
      .req_ready(rdy[0]), .resp_valid(vld[0]),
      .resp_rdata(rd[0]), .stall(stl[0])
   );

   data_mem_ctrl #(.ADDR_WIDTH(8), .LATENCY(1)) dut1 (
      .clock(clk), .reset(rst),
      .req_valid(rv[1]), .req_write(rw[1]), .req_byte(rb[1]),
      .req_addr(ra[1]), .req_wdata(wd[1]),
      .req_ready(rdy[1]), .resp_valid(vld[1]),
      .resp_rdata(rd[1]), .stall(stl[1])
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Reference model: timing from acceptance cycle, array as plain words
   int          lat [2] = '{3, 1};
   logic [31:0] mm [2][256];
   int          free_at [2];
   int          resp_at [2];
   logic        pw [2];
   logic        pb [2];
   logic [31:0] pa [2];
   logic [31:0] pd [2];
   logic [31:0] mrd [2];
   bit          mvalid = 0;
   bit          post_rst = 0;
   int          cyc = 0;

   always @(negedge clk) begin : model
      bit          e_rdy, e_resp, e_stl;
      int          idx, ln;
      logic [31:0] w;
      for (int k = 0; k < 2; k++) begin
         if (mvalid) begin
            e_rdy  = (cyc >= free_at[k]);
            e_resp = (cyc == resp_at[k]);
            e_stl  = e_rdy ? rv[k] : (cyc < resp_at[k]);
            chk($sformatf("ready%0d@%0d", k, cyc), 32'(rdy[k]), 32'(e_rdy));
            chk($sformatf("resp_valid%0d@%0d", k, cyc), 32'(vld[k]), 32'(e_resp));
            chk($sformatf("stall%0d@%0d", k, cyc), 32'(stl[k]), 32'(e_stl));
            if (e_resp || post_rst)
               chk($sformatf("rdata%0d@%0d", k, cyc), rd[k], mrd[k]);
         end
      end
      post_rst = rst;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            for (int i = 0; i < 256; i++) mm[k][i] = '0;
            free_at[k] = cyc + 1;
            resp_at[k] = -1;
            mrd[k] = '0;
         end else begin
            if (mvalid && cyc >= free_at[k] && rv[k]) begin
               pw[k] = rw[k];
               pb[k] = rb[k];
               pa[k] = ra[k];
               pd[k] = wd[k];
               resp_at[k] = cyc + lat[k];
               free_at[k] = cyc + lat[k] + 1;
            end
            if (cyc + 1 == resp_at[k]) begin
               idx = int'((pa[k] >> 2) % 256);
               ln  = int'(pa[k] % 4);
               w = mm[k][idx];
               if (pw[k]) begin
                  if (pb[k]) w[ln*8 +: 8] = pd[k][7:0];
                  else w = pd[k];
                  mm[k][idx] = w;
               end else begin
                  mrd[k] = pb[k] ? ((w >> (8 * ln)) & 32'hFF) : w;
               end
            end
         end
      end
      if (rst) mvalid = 1;
      cyc++;
   end

   task automatic do_req(input int k, input bit w, input bit b,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] data, output int l);
      int t0;
      int n;
      @(posedge clk); #1;
      rv[k] = 1'b1; rw[k] = w; rb[k] = b; ra[k] = a; wd[k] = d;
      n = 0;
      while (!rdy[k] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         n_chk++; n_fail++;
         $display("FAIL accept_timeout: inst %0d not ready", k);
      end
      t0 = cyc;
      @(posedge clk); #1;
      rv[k] = 1'b0;
      n = 0;
      while (!vld[k] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         n_chk++; n_fail++;
         $display("FAIL resp_timeout: inst %0d got none, required one", k);
      end
      data = rd[k];
      l = cyc - t0;
   endtask

   logic [31:0] d;
   int          l;
   logic [5:0]  sp, vp;
   logic [31:0] rdv [6];

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         rv[k] = 0; rw[k] = 0; rb[k] = 0; ra[k] = 0; wd[k] = 0;
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("post_reset_ready", 32'(rdy[0]), 32'd1);
      chk("post_reset_valid", 32'(vld[0]), 32'd0);
      chk("post_reset_rdata", rd[0], 32'd0);

      do_req(0, 0, 0, 32'h10, 0, d, l);
      chk("load0_data", d, 32'd0);
      chk("load0_latency", 32'(l), 32'd3);

      do_req(0, 1, 0, 32'h20, 32'hDEADBEEF, d, l);
      do_req(0, 0, 0, 32'h20, 0, d, l);
      chk("word_load_20", d, 32'hDEADBEEF);
      do_req(0, 0, 0, 32'h22, 0, d, l);
      chk("word_load_22", d, 32'hDEADBEEF);

      do_req(0, 1, 1, 32'h21, 32'h123456AA, d, l);
      do_req(0, 1, 1, 32'h23, 32'h00000055, d, l);
      do_req(0, 0, 0, 32'h20, 0, d, l);
      chk("byte_merge_word", d, 32'h55ADAAEF);
      chk("model_byte_merge", mm[0][8], 32'h55ADAAEF);
      do_req(0, 0, 1, 32'h23, 0, d, l);
      chk("byte_load_23", d, 32'h00000055);
      do_req(0, 0, 1, 32'h21, 0, d, l);
      chk("byte_load_21", d, 32'h000000AA);

      do_req(0, 1, 0, 32'h404, 32'h12345678, d, l);
      do_req(0, 0, 0, 32'h004, 0, d, l);
      chk("wrap_load", d, 32'h12345678);
      chk("model_wrap", mm[0][1], 32'h12345678);

      @(posedge clk); #1;
      rv[0] = 1; rw[0] = 1; rb[0] = 0; ra[0] = 32'h30; wd[0] = 32'hFFFFFFFF;
      @(posedge clk); #1;
      rv[0] = 0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_ready", 32'(rdy[0]), 32'd1);
      do_req(0, 0, 0, 32'h30, 0, d, l);
      chk("abort_load_30", d, 32'd0);

      do_req(1, 1, 0, 32'h40, 32'h11112222, d, l);
      chk("lat1_latency", 32'(l), 32'd1);
      do_req(1, 1, 0, 32'h80, 32'h33334444, d, l);
      @(posedge clk); #1;
      rv[1] = 1; rw[1] = 0; rb[1] = 0;
      for (int i = 0; i < 6; i++) begin
         ra[1] = ((i / 2) % 2 == 1) ? 32'h80 : 32'h40;
         @(negedge clk);
         sp[i] = stl[1];
         vp[i] = vld[1];
         rdv[i] = rd[1];
         @(posedge clk); #1;
      end
      rv[1] = 0;
      chk("lat1_stall_pattern", 32'(sp), 32'(6'b010101));
      chk("lat1_valid_pattern", 32'(vp), 32'(6'b101010));
      chk("lat1_rdata_a", rdv[1], 32'h11112222);
      chk("lat1_rdata_b", rdv[3], 32'h33334444);
      chk("lat1_rdata_c", rdv[5], 32'h11112222);

      for (int k = 0; k < 2; k++) begin
         repeat (400) begin
            @(posedge clk); #1;
            rst   = ($urandom_range(0, 149) == 0);
            rv[k] = 1'($urandom_range(0, 1));
            rw[k] = 1'($urandom_range(0, 1));
            rb[k] = 1'($urandom_range(0, 1));
            ra[k] = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63));
            wd[k] = $urandom;
         end
         @(posedge clk); #1;
         rst = 1'b0;
         rv[k] = 1'b0;
         repeat (10) @(posedge clk);
      end
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
